pipe_stage_skid: RTL and testbench

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

---
 rtl/pipe_pkg.sv | 37 +++
 rtl/pipe_stage_skid.sv | 189 ++++++++++++++++++
 tb/tb_pipe_stage_skid.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
//
// Shared definitions for the pipeline skid stage:
//   - PIPE_DATA_W   default payload width (ALU result 32 + write data 32 + rd 5)
//   - PIPE_CTRL_W   default control width (RegWrite, MemtoReg, MemWrite)
//   - STALL_CNT_W   width of the optional stall statistics counter
//   - skidStateT    occupancy state of the two-entry skid buffer
//   - satInc()      saturating increment for the stall counter
// -----------------------------------------------------------------------------
package pipe_pkg;

    localparam int unsigned PIPE_DATA_W = 69;
    localparam int unsigned PIPE_CTRL_W = 3;
    localparam int unsigned STALL_CNT_W = 16;

    localparam logic [STALL_CNT_W-1:0] STALL_CNT_MAX = '1;

    // EMPTY: nothing held. ONE: main slot full. TWO: main and skid slots full.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skidStateT;

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [STALL_CNT_W-1:0] satInc(input logic [STALL_CNT_W-1:0] value);
        logic [STALL_CNT_W-1:0] result;
        if (value == STALL_CNT_MAX) begin
            result = value;
        end else begin
            result = value + 1'b1;
        end
        return result;
    endfunction

endpackage

// File: rtl/pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// pipe_stage_skid
//
// One pipeline register stage built as a two-entry skid buffer. The main slot
// drives the outputs; the skid slot catches the one item that may arrive while
// downstream is stalled, so in_ready can come straight from a flop and never
// depends combinationally on out_ready.
//
// Ports:
//   CLK        in   sole clock, rising edge
//   RST_N      in   asynchronous active-low reset
//   in_valid   in   upstream item present
//   in_ready   out  stage can accept (decoded from registered state only)
//   in_ctrl    in   upstream control bits [CTRL_W]
//   in_data    in   upstream payload [DATA_W]
//   flush      in   discard all held items at the next edge
//   out_valid  out  downstream item present
//   out_ready  in   downstream accepts
//   out_ctrl   out  held control bits, zero whenever out_valid is low
//   out_data   out  held payload
//   stall_cnt  out  saturating stall counter, only with PIPE_STAGE_STATS_EN
//
// Build option:
//   PIPE_STAGE_STATS_EN  adds stall_cnt, counting edges with out_valid and
//                        !out_ready; cleared by reset only.
// -----------------------------------------------------------------------------
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = PIPE_DATA_W,
    parameter int unsigned CTRL_W = PIPE_CTRL_W
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

    // -------------------------------------------------------------------------
    // State and slot storage
    // -------------------------------------------------------------------------
    skidStateT         state;
    skidStateT         stateNext;

    logic [CTRL_W-1:0] mainCtrl;
    logic [DATA_W-1:0] mainData;
    logic [CTRL_W-1:0] skidCtrl;
    logic [DATA_W-1:0] skidData;

    // Handshakes, qualified by the registered ready/valid.
    logic              inXfer;
    logic              outXfer;

    // Slot load strobes from the next-state decode.
    logic              loadMainFromIn;
    logic              loadMainFromSkid;
    logic              loadSkidFromIn;

    assign inXfer  = in_valid && in_ready;
    assign outXfer = out_valid && out_ready;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= EMPTY;
        end else begin
            state <= stateNext;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and slot-load decode
    // -------------------------------------------------------------------------
    always_comb begin
        stateNext        = state;
        loadMainFromIn   = 1'b0;
        loadMainFromSkid = 1'b0;
        loadSkidFromIn   = 1'b0;

        if (flush) begin
            // Flush beats both handshakes: nothing is loaded, everything dropped.
            stateNext = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (inXfer) begin
                        stateNext      = ONE;
                        loadMainFromIn = 1'b1;
                    end
                end
                ONE: begin
                    if (inXfer && !outXfer) begin
                        stateNext      = TWO;
                        loadSkidFromIn = 1'b1;
                    end else if (inXfer && outXfer) begin
                        // Main leaves and is refilled on the same edge.
                        stateNext      = ONE;
                        loadMainFromIn = 1'b1;
                    end else if (outXfer) begin
                        stateNext = EMPTY;
                    end
                end
                TWO: begin
                    // in_ready is low here, so only the output side can move.
                    if (outXfer) begin
                        stateNext        = ONE;
                        loadMainFromSkid = 1'b1;
                    end
                end
                default: begin
                    stateNext = EMPTY;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Main and skid slots
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mainCtrl <= '0;
            mainData <= '0;
            skidCtrl <= '0;
            skidData <= '0;
        end else if (flush) begin
            // Only control is cleared; payload is left as-is.
            mainCtrl <= '0;
            skidCtrl <= '0;
        end else begin
            if (loadMainFromIn) begin
                mainCtrl <= in_ctrl;
                mainData <= in_data;
            end else if (loadMainFromSkid) begin
                mainCtrl <= skidCtrl;
                mainData <= skidData;
            end

            if (loadSkidFromIn) begin
                skidCtrl <= in_ctrl;
                skidData <= in_data;
            end else if (loadMainFromSkid) begin
                // Skid is vacated; keep its control bits from looking live.
                skidCtrl <= '0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs, decoded from registered state only
    // -------------------------------------------------------------------------
    always_comb begin
        out_valid = (state != EMPTY);
        in_ready  = (state != TWO);
        out_ctrl  = out_valid ? mainCtrl : '0;
        out_data  = mainData;
    end

`ifdef PIPE_STAGE_STATS_EN
    // -------------------------------------------------------------------------
    // Stall statistics; flush deliberately does not clear this.
    // -------------------------------------------------------------------------
    logic [STALL_CNT_W-1:0] stallCnt;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            stallCnt <= '0;
        end else if (out_valid && !out_ready) begin
            stallCnt <= satInc(stallCnt);
        end
    end

    assign stall_cnt = stallCnt;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;
    import pipe_pkg::*;

    localparam int unsigned DW = PIPE_DATA_W;
    localparam int unsigned CW = PIPE_CTRL_W;
    localparam int unsigned IW = DW + CW;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [CW-1:0] in_ctrl = '0;
    logic [DW-1:0] in_data = '0;
    logic          flush = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
`ifdef PIPE_STAGE_STATS_EN
    logic [15:0]   stall_cnt;
`endif

    int checks = 0;
    int fails  = 0;

    // Reference model: FIFO of held items (at most two), head is what is shown.
    logic [IW-1:0] model[$];
    int unsigned   stallExp = 0;

    always #5 CLK = ~CLK;

    pipe_stage_skid dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data)
`ifdef PIPE_STAGE_STATS_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    function automatic logic [DW-1:0] rand_data();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return r[DW-1:0];
    endfunction

    function automatic logic [CW-1:0] rand_ctrl();
        logic [31:0] r;
        r = $urandom();
        return r[CW-1:0];
    endfunction

    function automatic logic exp_valid();
        return model.size() > 0;
    endfunction

    function automatic logic exp_ready();
        return model.size() < 2;
    endfunction

    function automatic logic [CW-1:0] exp_ctrl();
        logic [IW-1:0] head;
        if (model.size() == 0) return '0;
        head = model[0];
        return head[IW-1:DW];
    endfunction

    function automatic logic [DW-1:0] exp_data();
        logic [IW-1:0] head;
        head = model[0];
        return head[DW-1:0];
    endfunction

    // Drive one cycle of inputs, advance the model by one edge, and return
    // 1 time unit after that edge.
    task automatic drive_cycle(input logic iv, input logic [CW-1:0] c, input logic [DW-1:0] d,
                               input logic ordy, input logic fl);
        bit hasOut;
        bit canIn;
        in_valid  = iv;
        in_ctrl   = c;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        hasOut = model.size() > 0;
        canIn  = model.size() < 2;
        if (hasOut && !ordy && stallExp < 65535) stallExp++;
        if (fl) begin
            model.delete();
        end else begin
            if (hasOut && ordy) void'(model.pop_front());
            if (iv && canIn) model.push_back({c, d});
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (out_valid !== 1'b0) begin
            fails++; $display("FAIL reset_valid: got %b expected 0", out_valid);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            fails++; $display("FAIL reset_ready: got %b expected 1", in_ready);
        end
        @(posedge CLK); @(posedge CLK); #1;
        checks++;
        if (out_ctrl !== '0) begin
            fails++; $display("FAIL reset_ctrl: got %0h expected 0", out_ctrl);
        end
        checks++;
        if (out_data !== '0) begin
            fails++; $display("FAIL reset_data: got %0h expected 0", out_data);
        end
        @(negedge CLK);
        RST_N = 1'b1;
        model.delete();
        stallExp = 0;
    endtask

    task automatic test_single();
        logic [DW-1:0] d;
        d = 69'h1_2345_6789_ABCD_EF01;
        drive_cycle(1'b1, 3'b101, d, 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b1) begin
            fails++; $display("FAIL single_valid: got %b expected 1", out_valid);
        end
        checks++;
        if (out_ctrl !== 3'b101) begin
            fails++; $display("FAIL single_ctrl: got %b expected 101", out_ctrl);
        end
        checks++;
        if (out_data !== d) begin
            fails++; $display("FAIL single_data: got %0h expected %0h", out_data, d);
        end
        drive_cycle(1'b0, '0, '0, 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b0 || out_ctrl !== '0) begin
            fails++; $display("FAIL single_after: got v=%b c=%b expected v=0 c=0", out_valid, out_ctrl);
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] a, b;
        a = rand_data();
        b = rand_data();
        drive_cycle(1'b1, 3'b001, a, 1'b0, 1'b0);
        drive_cycle(1'b1, 3'b010, b, 1'b0, 1'b0);
        checks++;
        if (in_ready !== 1'b0) begin
            fails++; $display("FAIL bp_full_ready: got %b expected 0", in_ready);
        end
        checks++;
        if (out_valid !== 1'b1 || out_data !== a || out_ctrl !== 3'b001) begin
            fails++; $display("FAIL bp_head_a: got v=%b c=%b d=%0h expected v=1 c=001 d=%0h",
                              out_valid, out_ctrl, out_data, a);
        end
        drive_cycle(1'b0, '0, '0, 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_data !== b || out_ctrl !== 3'b010) begin
            fails++; $display("FAIL bp_head_b: got v=%b c=%b d=%0h expected v=1 c=010 d=%0h",
                              out_valid, out_ctrl, out_data, b);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            fails++; $display("FAIL bp_ready_after_a: got %b expected 1", in_ready);
        end
        drive_cycle(1'b0, '0, '0, 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin
            fails++; $display("FAIL bp_drained: got %b expected 0", out_valid);
        end
    endtask

    task automatic test_throughput();
        logic [DW-1:0] d;
        logic [CW-1:0] c;
        int outs;
        outs = 0;
        for (int i = 0; i < 100; i++) begin
            d = rand_data();
            c = rand_ctrl();
            checks++;
            if (in_ready !== 1'b1) begin
                fails++; $display("FAIL thru_ready[%0d]: got %b expected 1", i, in_ready);
            end
            drive_cycle(1'b1, c, d, 1'b1, 1'b0);
            if (out_valid === 1'b1) outs++;
            checks++;
            if (out_data !== d || out_ctrl !== c) begin
                fails++; $display("FAIL thru_item[%0d]: got c=%b d=%0h expected c=%b d=%0h",
                                  i, out_ctrl, out_data, c, d);
            end
        end
        checks++;
        if (outs != 100) begin
            fails++; $display("FAIL thru_count: got %0d expected 100", outs);
        end
        drive_cycle(1'b0, '0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_flush();
        drive_cycle(1'b1, 3'b111, rand_data(), 1'b0, 1'b0);
        drive_cycle(1'b1, 3'b110, rand_data(), 1'b0, 1'b0);
        drive_cycle(1'b1, 3'b011, rand_data(), 1'b1, 1'b1);
        checks++;
        if (out_valid !== 1'b0 || out_ctrl !== '0) begin
            fails++; $display("FAIL flush_out: got v=%b c=%b expected v=0 c=0", out_valid, out_ctrl);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            fails++; $display("FAIL flush_ready: got %b expected 1", in_ready);
        end
        drive_cycle(1'b0, '0, '0, 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin
            fails++; $display("FAIL flush_input_dropped: got %b expected 0", out_valid);
        end
    endtask

    task automatic test_async_reset();
        logic [DW-1:0] d;
        drive_cycle(1'b1, 3'b100, rand_data(), 1'b0, 1'b0);
        in_valid = 1'b0;
        #2;
        RST_N = 1'b0;
        #1;
        model.delete();
        stallExp = 0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_ctrl !== '0) begin
            fails++; $display("FAIL async_reset: got v=%b r=%b c=%b expected v=0 r=1 c=0",
                              out_valid, in_ready, out_ctrl);
        end
        @(negedge CLK);
        RST_N = 1'b1;
        d = rand_data();
        drive_cycle(1'b1, 3'b010, d, 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_data !== d || out_ctrl !== 3'b010) begin
            fails++; $display("FAIL post_reset_item: got v=%b c=%b d=%0h expected v=1 c=010 d=%0h",
                              out_valid, out_ctrl, out_data, d);
        end
        drive_cycle(1'b0, '0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 2000; i++) begin
            drive_cycle($urandom_range(0, 3) != 0, rand_ctrl(), rand_data(),
                        $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
            checks++;
            if (out_valid !== exp_valid() || in_ready !== exp_ready()) begin
                fails++; $display("FAIL rand_hs[%0d]: got v=%b r=%b expected v=%b r=%b",
                                  i, out_valid, in_ready, exp_valid(), exp_ready());
            end
            checks++;
            if (out_ctrl !== exp_ctrl()) begin
                fails++; $display("FAIL rand_ctrl[%0d]: got %b expected %b", i, out_ctrl, exp_ctrl());
            end
            if (exp_valid()) begin
                checks++;
                if (out_data !== exp_data()) begin
                    fails++; $display("FAIL rand_data[%0d]: got %0h expected %0h",
                                      i, out_data, exp_data());
                end
            end
`ifdef PIPE_STAGE_STATS_EN
            checks++;
            if (stall_cnt !== 16'(stallExp)) begin
                fails++; $display("FAIL rand_stall[%0d]: got %0d expected %0d", i, stall_cnt, stallExp);
            end
`endif
        end
        drive_cycle(1'b0, '0, '0, 1'b1, 1'b1);
    endtask

`ifdef PIPE_STAGE_STATS_EN
    task automatic test_stall_cnt();
        logic [DW-1:0] d;
        d = rand_data();
        drive_cycle(1'b1, 3'b001, d, 1'b0, 1'b0);
        for (int i = 0; i < 70000; i++) begin
            drive_cycle(1'b0, '0, '0, 1'b0, 1'b0);
        end
        checks++;
        if (stall_cnt !== 16'hFFFF || stallExp != 65535) begin
            fails++; $display("FAIL stall_sat: got %0h expected ffff", stall_cnt);
        end
        checks++;
        if (out_valid !== 1'b1 || out_data !== d) begin
            fails++; $display("FAIL stall_hold: got v=%b d=%0h expected v=1 d=%0h", out_valid, out_data, d);
        end
        drive_cycle(1'b0, '0, '0, 1'b1, 1'b1);
        checks++;
        if (stall_cnt !== 16'hFFFF || out_valid !== 1'b0) begin
            fails++; $display("FAIL stall_after_flush: got cnt=%0h v=%b expected cnt=ffff v=0",
                              stall_cnt, out_valid);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_throughput();
        test_flush();
        test_async_reset();
        test_random();
`ifdef PIPE_STAGE_STATS_EN
        test_stall_cnt();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
